adder_sweep_ctrl: RTL and testbench

- Sequential stimulus/checker stage that sits directly upstream of the 8-bit CLA-vs-CRA comparison top.
- Drives every operand combination (A, B, cIn) into that top and waits a programmable settle time per vector.
- Samples the top's compare output and accumulates pass/fail statistics.
- Captures the first failing vector, replacing hand-written directed stimulus with an exhaustive, self-checking sweep.

---
 rtl/adder_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_adder_sweep_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sweep_ctrl.sv
// Exhaustive operand sweep driver/checker for the CLA-vs-CRA comparison top.
// Latency: each vector is held SETTLE_CYCLES clocks and sampled on the next one (SETTLE_CYCLES+1 per vector).
// Backpressure: none; start is ignored while busy, and abort stops a running sweep with results frozen.
module adder_sweep_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               compare,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic               cIn,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH+1:0] pass_count,
  output logic [2*WIDTH+1:0] err_count,
  output logic               first_fail_valid,
  output logic [2*WIDTH:0]   first_fail_vec
);

  localparam int VEC_W = 2*WIDTH + 1;
  localparam int CNT_W = 2*WIDTH + 2;
  // Last settle-counter value before the vector is sampled.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   idx_q, idx_d;
  logic [3:0]         settle_q, settle_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               ffv_q, ffv_d;
  logic [VEC_W-1:0]   ffvec_q, ffvec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operands come straight from the vector index, cIn as the most significant bit,
  // so the sweep order is B fastest, then A, then cIn.
  assign B                = idx_q[WIDTH-1:0];
  assign A                = idx_q[2*WIDTH-1:WIDTH];
  assign cIn              = idx_q[2*WIDTH];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass_count       = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

  // Next-state and next-result computation for the sweep FSM.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    busy_d   = busy_q;
    done_d   = done_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // abort has no meaning here; start always restarts from a clean slate.
        if (start) begin
          state_d  = ST_SETTLE;
          idx_d    = '0;
          settle_d = '0;
          pass_d   = '0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          settle_d = '0;
          busy_d   = 1'b0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        // An aborted sample is discarded: the vector is not counted.
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (compare) begin
            pass_d = pass_q + CNT_W'(1);
          end else begin
            err_d = err_q + CNT_W'(1);
            // Only the first failure in sweep order is kept.
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = idx_q;
            end
          end
          if (&idx_q) begin
            // Final vector: idx stays at all-ones so the last operands remain driven.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + VEC_W'(1);
            state_d = ST_SETTLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset clears everything including partial results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      pass_q   <= '0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Directed bench for adder_sweep_ctrl at WIDTH=4, SETTLE_CYCLES=2 (512 vectors, 3 clocks each).
// The comparison top is modelled as "agree" except for up to two injected failing vectors.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_adder_sweep_ctrl;

  localparam int W   = 4;
  localparam int SC  = 2;
  localparam int NV  = 1 << (2*W + 1);
  localparam int LAT = NV * (SC + 1);

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             compare;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             cIn;
  logic             busy;
  logic             done;
  logic [2*W+1:0]   pass_count;
  logic [2*W+1:0]   err_count;
  logic             first_fail_valid;
  logic [2*W:0]     first_fail_vec;

  // Failure-injection model of the comparison top.
  logic             fe0, fe1;
  logic [2*W:0]     fv0, fv1;
  logic [2*W:0]     vec;

  int checks;
  int failures;
  int edge_cnt;
  int t0;

  adder_sweep_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .compare          (compare),
    .A                (A),
    .B                (B),
    .cIn              (cIn),
    .busy             (busy),
    .done             (done),
    .pass_count       (pass_count),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  assign vec     = {cIn, A, B};
  assign compare = !((fe0 && vec == fv0) || (fe1 && vec == fv1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Start a sweep, then wait (bounded) for done and check the start-to-done latency.
  task automatic run_sweep(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = edge_cnt;
    chk({tag, "_start_busy"}, 32'(busy), 32'd1);
    chk({tag, "_start_done"}, 32'(done), 32'd0);
    chk({tag, "_start_pass"}, 32'(pass_count), 32'd0);
    chk({tag, "_start_err"},  32'(err_count), 32'd0);
    while (!done && (edge_cnt - t0) < LAT + 20) step();
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(edge_cnt - t0), 32'(LAT));
  endtask

  task automatic wait_vec(input logic [2*W:0] target);
    int n;
    n = 0;
    while (vec != target && n < LAT) begin
      step();
      n++;
    end
    chk("wait_vec_reached", 32'(vec), 32'(target));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    edge_cnt = 0;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    fe0 = 1'b0; fe1 = 1'b0;
    fv0 = '0;   fv1 = '0;

    // Asynchronous reset, between edges.
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec",  32'(vec), 32'd0);
    chk("rst_pass", 32'(pass_count), 32'd0);
    chk("rst_err",  32'(err_count), 32'd0);
    chk("rst_ffv",  32'(first_fail_valid), 32'd0);
    chk("rst_ffvec", 32'(first_fail_vec), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Timing of the first vectors and ignored start while busy.
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = edge_cnt;
    chk("t_e0_busy", 32'(busy), 32'd1);
    chk("t_e0_vec",  32'(vec), 32'd0);
    step();
    chk("t_e1_vec",  32'(vec), 32'd0);
    step();
    chk("t_e2_vec",  32'(vec), 32'd0);
    chk("t_e2_pass", 32'(pass_count), 32'd0);
    step();
    chk("t_e3_vec",  32'(vec), 32'd1);
    chk("t_e3_pass", 32'(pass_count), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_pass", 32'(pass_count), 32'd1);
    chk("busy_start_vec",  32'(vec), 32'd1);
    chk("busy_start_busy", 32'(busy), 32'd1);
    while (!done && (edge_cnt - t0) < LAT + 20) step();
    chk("clean_done_seen", 32'(done), 32'd1);
    chk("clean_latency", 32'(edge_cnt - t0), 32'(LAT));
    chk("clean_busy", 32'(busy), 32'd0);
    chk("clean_pass", 32'(pass_count), 32'(NV));
    chk("clean_err",  32'(err_count), 32'd0);
    chk("clean_ffv",  32'(first_fail_valid), 32'd0);
    chk("clean_vec",  32'(vec), 32'h1FF);
    step(); step(); step();
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_pass", 32'(pass_count), 32'(NV));
    chk("hold_vec",  32'(vec), 32'h1FF);

    // One failing vector: A=15, B=10, cIn=0.
    fe0 = 1'b1; fv0 = 9'h0FA;
    run_sweep("one");
    chk("one_pass",  32'(pass_count), 32'(NV - 1));
    chk("one_err",   32'(err_count), 32'd1);
    chk("one_ffv",   32'(first_fail_valid), 32'd1);
    chk("one_ffvec", 32'(first_fail_vec), 32'h0FA);

    // Two failures: A=1,B=12,cIn=0 comes first; A=12,B=3,cIn=1 must not overwrite it.
    fv0 = 9'h01C;
    fe1 = 1'b1; fv1 = 9'h1C3;
    run_sweep("two");
    chk("two_pass",  32'(pass_count), 32'(NV - 2));
    chk("two_err",   32'(err_count), 32'd2);
    chk("two_ffv",   32'(first_fail_valid), 32'd1);
    chk("two_ffvec", 32'(first_fail_vec), 32'h01C);

    // Abort while A=3, B=7: 0x37 vectors already passed, all frozen afterwards.
    fe0 = 1'b0; fe1 = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ab_start_done", 32'(done), 32'd0);
    wait_vec(9'h037);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_pass", 32'(pass_count), 32'h37);
    chk("ab_vec",  32'(vec), 32'h037);
    step(); step(); step(); step();
    chk("ab_frozen_pass", 32'(pass_count), 32'h37);
    chk("ab_frozen_vec",  32'(vec), 32'h037);
    chk("ab_frozen_busy", 32'(busy), 32'd0);

    // In IDLE, start wins over abort and restarts from vector 0.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("idle_sa_busy", 32'(busy), 32'd1);
    chk("idle_sa_pass", 32'(pass_count), 32'd0);
    chk("idle_sa_vec",  32'(vec), 32'd0);
    step(); step(); step();
    chk("re_vec1",  32'(vec), 32'd1);
    chk("re_pass1", 32'(pass_count), 32'd1);
    // Two more edges place the FSM in SAMPLE for vector 1; abort+start there aborts
    // and the vector is not counted.
    step(); step();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("samp_ab_busy", 32'(busy), 32'd0);
    chk("samp_ab_pass", 32'(pass_count), 32'd1);
    chk("samp_ab_vec",  32'(vec), 32'd1);
    chk("samp_ab_done", 32'(done), 32'd0);

    // Asynchronous reset mid-sweep, then a full sweep with one failure.
    fe0 = 1'b1; fv0 = 9'h0FA;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_vec",  32'(vec), 32'd0);
    chk("mrst_pass", 32'(pass_count), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    #1 rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_sweep("rst");
    chk("rst_sw_pass",  32'(pass_count), 32'(NV - 1));
    chk("rst_sw_err",   32'(err_count), 32'd1);
    chk("rst_sw_ffv",   32'(first_fail_valid), 32'd1);
    chk("rst_sw_ffvec", 32'(first_fail_vec), 32'h0FA);
    chk("rst_sw_vec",   32'(vec), 32'h1FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
